tinker_mem_ctrl: RTL and testbench
==================================

// Module: tinker_mem_ctrl
// PURPOSE
//  Parametrised successor to the tinker unified byte memory: one byte array shared by a fetch port and a data port.
//  A fixed-priority arbiter with starvation guard sits in front of the array.
//  Reads use a configurable-latency, in-order response pipeline.
//  The data port has byte-enable writes and out-of-range fault reporting.
//  Sits between the core's IF stage and its MEM stage; replaces the combinational-read memory.
// PARAMETERS
//  MEM_BYTES   524288  array size in bytes (power of two)
//  ADDR_W      64      address width on both ports
//  RD_LAT      2       accept-to-response latency in cycles, legal 1..4
//  STARVE_MAX  3       max consecutive data grants while a fetch is pending
// PORTS
//  clk        in   1           single clock, all state on rising edge
//  reset_n    in   1           asynchronous, active-low reset
//  if_req     in   1           fetch request (read 4 bytes)
//  if_addr    in   ADDR_W      fetch byte address (any alignment)
//  if_ready   out  1           fetch accepted this cycle
//  if_valid   out  1           fetch response valid (one-cycle pulse)
//  if_rdata   out  32          little-endian instruction word
//  if_fault   out  1           fetch address range exceeded MEM_BYTES
//  d_req      in   1           data request
//  d_we       in   1           1 = write, 0 = read
//  d_addr     in   ADDR_W      data byte address (any alignment)
//  d_wdata    in   64          write data, little-endian
//  d_be       in   8           byte enables; bit i enables byte addr+i
//  d_ready    out  1           data request accepted this cycle
//  d_valid    out  1           data response valid (reads and writes)
//  d_rdata    out  64          read data (0 on write or fault)
//  d_fault    out  1           data access range exceeded MEM_BYTES
// BEHAVIOUR
//  - Reset (reset_n=0, async): all outputs 0, response pipeline cleared, starve counter 0.
//    Array contents are NOT reset.
//  - Arbitration is combinational, one grant per cycle.
//    Data wins when both ports request, unless starve_cnt==STARVE_MAX with if_req=1; then fetch wins.
//  - starve_cnt increments on each data grant while if_req=1.
//    It clears on a fetch grant, or when if_req=0.
//  - ready is asserted only in the grant cycle. The requester holds req/addr/data until it sees ready.
//  - Read: bytes are sampled at the accept edge and pushed into the pipeline.
//    The response is presented exactly RD_LAT cycles after the accept edge.
//    Responses are in order per port. There is no response backpressure.
//  - Write: bytes with d_be[i]=1 are committed at the accept edge. d_valid pulses after RD_LAT with d_rdata=0.
//    A read accepted on a later cycle sees the written data.
//  - Fault: an access faults if addr+N-1 >= MEM_BYTES (N=4 fetch, 8 data) or the add wraps ADDR_W.
//    A faulting access is still accepted and gets valid+fault after RD_LAT with rdata=0.
//    A faulting write modifies no byte.
//  - Back-to-back accepts are allowed every cycle; pipeline depth is RD_LAT, so it never overflows.
//  - Reset mid-operation: in-flight responses are discarded, with no valid after release.
//    A write accepted before the reset edge stays committed.
//  - if_fault, d_fault and rdata are meaningful only while the matching valid is 1.
// STRUCTURE
//  - Shared package tinker_mem_pkg: port-id enum (PORT_IF, PORT_D), MEM_BYTES default, response struct {valid, port, fault, data[63:0]}.
//  - Sub-module tinker_mem_lat_pipe: RD_LAT-deep shift register of response structs with async active-low clear.
//    Instantiated once, shared by both ports and tagged by port id.
//  - Top level holds the arbiter, starve counter, range check, byte array and write-enable expansion.
// TESTING
//  1. Write 64'h1122334455667788 to 0x100 with be=8'hFF, then read 0x100.
//     -> d_valid exactly 2 cycles after accept, d_rdata=64'h1122334455667788.
//  2. Then write 64'hFFFFFFFFFFFFFFFF to 0x100 with be=8'h0F, then read.
//     -> d_rdata=64'h11223344FFFFFFFF.
//  3. if_req and d_req asserted in the same cycle.
//     -> d_ready=1, if_ready=0; next cycle (d_req=0) if_ready=1; if_valid 2 cycles later.
//  4. d_req held 5 cycles with if_req held, STARVE_MAX=3.
//     -> data granted cycles 1-3, fetch granted cycle 4, data granted cycle 5.
//  5. Read d_addr=MEM_BYTES-4.
//     -> d_valid=1, d_fault=1, d_rdata=0.
//     Write at the same address -> fault, and a later read of MEM_BYTES-8 is unchanged.
//  6. Two reads in flight, reset_n pulsed low for 1 cycle.
//     -> no d_valid after release, and a re-read returns the pre-reset memory value.

Source files
------------

// File: rtl/tinker_mem_pkg.sv
// Shared types for the tinker unified byte memory: port identifiers and the
// response record carried through the read-latency pipeline.
package tinker_mem_pkg;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    localparam int unsigned MEM_BYTES_DEF = 524288;

    typedef struct packed {
        logic        valid;
        port_e       port;
        logic        fault;
        logic [63:0] data;
    } resp_t;

endpackage

// File: rtl/tinker_mem_lat_pipe.sv
// RD_LAT-deep in-order response shift register shared by both ports.
// Only the valid bits are cleared by reset; payload is qualified by valid.
module tinker_mem_lat_pipe
    import tinker_mem_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  resp_t in_resp,
    output resp_t out_resp
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    port_e             port_q  [RD_LAT];
    port_e             port_d  [RD_LAT];
    logic              fault_q [RD_LAT];
    logic              fault_d [RD_LAT];
    logic [63:0]       data_q  [RD_LAT];
    logic [63:0]       data_d  [RD_LAT];

    always_comb begin
        vld_d[0]   = in_resp.valid;
        port_d[0]  = in_resp.port;
        fault_d[0] = in_resp.fault;
        data_d[0]  = in_resp.data;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            port_d[i]  = port_q[i-1];
            fault_d[i] = fault_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        port_q  <= port_d;
        fault_q <= fault_d;
        data_q  <= data_d;
    end

    always_comb begin
        out_resp.valid = vld_q[RD_LAT-1];
        out_resp.port  = port_q[RD_LAT-1];
        out_resp.fault = fault_q[RD_LAT-1];
        out_resp.data  = data_q[RD_LAT-1];
    end

endmodule

// File: rtl/tinker_mem_ctrl.sv
// Unified byte memory with a fetch port and a data port: fixed-priority
// arbiter with starvation guard, range checking, byte-enable writes.
module tinker_mem_ctrl
    import tinker_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = MEM_BYTES_DEF,
    parameter int unsigned ADDR_W     = 64,
    parameter int          RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    output logic              if_fault,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    input  logic [7:0]        d_be,
    output logic              d_ready,
    output logic              d_valid,
    output logic [63:0]       d_rdata,
    output logic              d_fault
);

    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [7:0]        byte_mem [MEM_BYTES];
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              d_grant, if_grant, starved;
    logic [ADDR_W:0]   if_end, d_end;
    logic              if_oob, d_oob;
    logic [IDX_W-1:0]  if_idx, d_idx;
    logic [31:0]       if_bytes;
    logic [63:0]       d_bytes;
    resp_t             push_resp, pipe_resp;

    // Data has priority unless the fetch port has been passed over STARVE_MAX times.
    always_comb begin
        starved      = if_req && (starve_cnt_q == CNT_W'(STARVE_MAX));
        d_grant      = reset_n && d_req && !starved;
        if_grant     = reset_n && if_req && !d_grant;
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_grant) begin
            starve_cnt_d = '0;
        end else if (d_grant) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Widened sum catches address wrap as well as running off the array end.
    always_comb begin
        if_end = {1'b0, if_addr} + (ADDR_W+1)'(3);
        d_end  = {1'b0, d_addr} + (ADDR_W+1)'(7);
        if_oob = if_end >= (ADDR_W+1)'(MEM_BYTES);
        d_oob  = d_end >= (ADDR_W+1)'(MEM_BYTES);
        if_idx = if_addr[IDX_W-1:0];
        d_idx  = d_addr[IDX_W-1:0];
        for (int i = 0; i < 4; i++) begin
            if_bytes[8*i +: 8] = byte_mem[if_idx + IDX_W'(i)];
        end
        for (int i = 0; i < 8; i++) begin
            d_bytes[8*i +: 8] = byte_mem[d_idx + IDX_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (d_grant && d_we && !d_oob) begin
            for (int i = 0; i < 8; i++) begin
                if (d_be[i]) begin
                    byte_mem[d_idx + IDX_W'(i)] <= d_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        push_resp = '0;
        if (d_grant) begin
            push_resp.valid = 1'b1;
            push_resp.port  = PORT_D;
            push_resp.fault = d_oob;
            push_resp.data  = (d_we || d_oob) ? 64'd0 : d_bytes;
        end else if (if_grant) begin
            push_resp.valid = 1'b1;
            push_resp.port  = PORT_IF;
            push_resp.fault = if_oob;
            push_resp.data  = if_oob ? 64'd0 : {32'd0, if_bytes};
        end
    end

    tinker_mem_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_lat_pipe (
        .clk      (clk),
        .rst_n    (reset_n),
        .in_resp  (push_resp),
        .out_resp (pipe_resp)
    );

    always_comb begin
        d_ready  = d_grant;
        if_ready = if_grant;
        d_valid  = pipe_resp.valid && (pipe_resp.port == PORT_D);
        if_valid = pipe_resp.valid && (pipe_resp.port == PORT_IF);
        d_fault  = d_valid && pipe_resp.fault;
        if_fault = if_valid && pipe_resp.fault;
        d_rdata  = d_valid ? pipe_resp.data : 64'd0;
        if_rdata = if_valid ? pipe_resp.data[31:0] : 32'd0;
    end

endmodule

// File: tb/tb_tinker_mem_ctrl.sv
// Scoreboard bench for tinker_mem_ctrl: drivers push expected responses,
// a negedge monitor pops and compares whenever a valid appears.
module tb_tinker_mem_ctrl;

    localparam int unsigned MB  = 524288;
    localparam int          LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ready, if_valid, if_fault;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [63:0] d_addr = '0, d_wdata = '0;
    logic [7:0]  d_be = '0;
    logic        d_ready, d_valid, d_fault;
    logic [63:0] d_rdata;

    tinker_mem_ctrl #(
        .MEM_BYTES (MB), .ADDR_W (64), .RD_LAT (LAT), .STARVE_MAX (3)
    ) dut (
        .clk (clk), .reset_n (reset_n),
        .if_req (if_req), .if_addr (if_addr), .if_ready (if_ready),
        .if_valid (if_valid), .if_rdata (if_rdata), .if_fault (if_fault),
        .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
        .d_be (d_be), .d_ready (d_ready), .d_valid (d_valid),
        .d_rdata (d_rdata), .d_fault (d_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic        fault;
        int          due;
    } exp_t;

    exp_t q_d[$];
    exp_t q_if[$];
    exp_t e_d, e_if;
    int   n_chk = 0;
    int   n_fail = 0;
    int   d_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (d_valid) begin
            d_seen++;
            if (q_d.size() == 0) begin
                chk("d_unexpected_valid", 64'(d_valid), 64'd0);
            end else begin
                e_d = q_d.pop_front();
                chk("d_rdata", d_rdata, e_d.data);
                chk("d_fault", 64'(d_fault), 64'(e_d.fault));
                chk("d_latency", 64'(cyc), 64'(e_d.due));
            end
        end
        if (if_valid) begin
            if (q_if.size() == 0) begin
                chk("if_unexpected_valid", 64'(if_valid), 64'd0);
            end else begin
                e_if = q_if.pop_front();
                chk("if_rdata", 64'(if_rdata), e_if.data);
                chk("if_fault", 64'(if_fault), 64'(e_if.fault));
                chk("if_latency", 64'(cyc), 64'(e_if.due));
            end
        end
    end

    task automatic d_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [7:0] be, input logic [63:0] exp_data,
                            input logic exp_fault, output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
        acc = -1;
        n = 0;
        #1;
        while (!d_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!d_ready) begin
            chk("d_ready_timeout", 64'(d_ready), 64'd1);
        end else begin
            acc = cyc;
            e.data = exp_data; e.fault = exp_fault; e.due = cyc + LAT;
            q_d.push_back(e);
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    task automatic if_fetch(input logic [63:0] addr, input logic [31:0] exp_data,
                            input logic exp_fault, output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        if_req = 1'b1; if_addr = addr;
        acc = -1;
        n = 0;
        #1;
        while (!if_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!if_ready) begin
            chk("if_ready_timeout", 64'(if_ready), 64'd1);
        end else begin
            acc = cyc;
            e.data = {32'd0, exp_data}; e.fault = exp_fault; e.due = cyc + LAT;
            q_if.push_back(e);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3, fa, dummy, snap;

        // Reset state, including a request held during reset.
        d_req = 1'b1;
        #3;
        chk("rst_d_ready", 64'(d_ready), 64'd0);
        chk("rst_if_ready", 64'(if_ready), 64'd0);
        chk("rst_d_valid", 64'(d_valid), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_faults", {62'd0, d_fault, if_fault}, 64'd0);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Full write, read back; then partial byte-enable write.
        d_access(1'b1, 64'h100, 64'h1122334455667788, 8'hFF, 64'd0, 1'b0, dummy);
        d_access(1'b0, 64'h100, 64'd0, 8'h00, 64'h1122334455667788, 1'b0, dummy);
        d_access(1'b1, 64'h100, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'd0, 1'b0, dummy);
        d_access(1'b0, 64'h100, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, dummy);

        // Simultaneous requests: data first, fetch (unaligned) one cycle later.
        fork
            d_access(1'b0, 64'h100, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, a0);
            if_fetch(64'h102, 32'h3344FFFF, 1'b0, fa);
        join
        chk("arb_fetch_after_data", 64'(fa), 64'(a0 + 1));

        // Starvation guard: three data grants, then fetch, then data.
        fork
            begin
                d_access(1'b0, 64'h100, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, a0);
                d_access(1'b0, 64'h100, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, a1);
                d_access(1'b0, 64'h100, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, a2);
                d_access(1'b0, 64'h100, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, a3);
            end
            if_fetch(64'h104, 32'h11223344, 1'b0, fa);
        join
        chk("starve_d1", 64'(a1), 64'(a0 + 1));
        chk("starve_d2", 64'(a2), 64'(a0 + 2));
        chk("starve_if", 64'(fa), 64'(a0 + 3));
        chk("starve_d3", 64'(a3), 64'(a0 + 4));

        // Range boundaries and faults.
        d_access(1'b1, 64'(MB - 8), 64'h0102030405060708, 8'hFF, 64'd0, 1'b0, dummy);
        d_access(1'b0, 64'(MB - 4), 64'd0, 8'h00, 64'd0, 1'b1, dummy);
        d_access(1'b1, 64'(MB - 4), 64'hAAAAAAAAAAAAAAAA, 8'hFF, 64'd0, 1'b1, dummy);
        d_access(1'b0, 64'(MB - 8), 64'd0, 8'h00, 64'h0102030405060708, 1'b0, dummy);
        d_access(1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, 8'h00, 64'd0, 1'b1, dummy);
        if_fetch(64'(MB - 4), 32'h01020304, 1'b0, dummy);
        if_fetch(64'(MB - 3), 32'd0, 1'b1, dummy);
        if_fetch(64'hFFFFFFFFFFFFFFFE, 32'd0, 1'b1, dummy);

        // Reset with a write and two reads in flight.
        repeat (LAT + 2) @(negedge clk);
        d_access(1'b1, 64'h200, 64'hCAFEF00D12345678, 8'hFF, 64'd0, 1'b0, dummy);
        d_access(1'b0, 64'h100, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, dummy);
        d_access(1'b0, 64'h100, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, dummy);
        #1;
        reset_n = 1'b0;
        q_d.delete();
        q_if.delete();
        #1;
        chk("midrst_d_valid", 64'(d_valid), 64'd0);
        chk("midrst_d_rdata", d_rdata, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        snap = d_seen;
        repeat (LAT + 4) @(negedge clk);
        chk("no_valid_after_reset", 64'(d_seen - snap), 64'd0);
        d_access(1'b0, 64'h100, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0, dummy);
        d_access(1'b0, 64'h200, 64'd0, 8'h00, 64'hCAFEF00D12345678, 1'b0, dummy);

        repeat (LAT + 3) @(negedge clk);
        chk("d_queue_drained", 64'(q_d.size()), 64'd0);
        chk("if_queue_drained", 64'(q_if.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
